// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared BTB types and PC field helpers
package btb_pkg;

  typedef enum logic {BTB_IDLE, BTB_FLUSH} btb_state_t;

  // Field types for the default LC-3b front end (4 ways, 8 sets, 16-bit PCs);
  // the RTL derives its own widths from its parameters.
  typedef logic [2:0]  btb_idx_t;
  typedef logic [11:0] btb_tag_t;
  typedef logic [1:0]  btb_way_t;
  typedef logic [2:0]  btb_plru_t;

  function automatic btb_idx_t idx_of(input logic [15:0] pc);
    return pc[3:1];
  endfunction

  function automatic btb_tag_t tag_of(input logic [15:0] pc);
    return pc[15:4];
  endfunction

endpackage

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - combinational heap-ordered tree-PLRU touch and victim select
module plru_tree #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         plru,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  output logic [WAYS-2:0]         plru_next,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int LVLS = $clog2(WAYS);

  // Victim and touch live in separate blocks so a touch driven by the victim never forms a loop.
  always_comb begin : find_victim
    int node;
    node   = 0;
    victim = '0;
    for (int l = 0; l < LVLS; l++) begin
      victim[LVLS-1-l] = plru[node];
      node = 2 * node + 1 + int'(plru[node]);
    end
  end

  always_comb begin : apply_touch
    int node;
    node      = 0;
    plru_next = plru;
    for (int l = 0; l < LVLS; l++) begin
      plru_next[node] = ~touch_way[LVLS-1-l];
      node = 2 * node + 1 + int'(touch_way[LVLS-1-l]);
    end
  end

endmodule

// File: rtl/btb_assoc_plru.sv
// rtl/btb_assoc_plru.sv - set-associative BTB with tree-PLRU replacement and flush sequencer
module btb_assoc_plru
  import btb_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int SETS   = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lk_valid,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              rd_valid,
  output logic              rd_hit,
  output logic [ADDR_W-1:0] rd_target,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_pc,
  input  logic [ADDR_W-1:0] wb_target,
  input  logic              flush_req,
  output logic              flush_busy
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - 1;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int PLRU_W = WAYS - 1;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [PLRU_W-1:0] plru_q  [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [ADDR_W-1:0] tgt_q   [SETS][WAYS];

  btb_state_t        state;
  logic [IDX_W-1:0]  flush_cnt;

  logic [IDX_W-1:0]  lk_idx, wb_idx;
  logic [TAG_W-1:0]  lk_tag, wb_tag;
  logic              unused_pc_lsb;

  assign lk_idx        = lk_pc[IDX_W:1];
  assign lk_tag        = lk_pc[ADDR_W-1:IDX_W+1];
  assign wb_idx        = wb_pc[IDX_W:1];
  assign wb_tag        = wb_pc[ADDR_W-1:IDX_W+1];
  assign unused_pc_lsb = lk_pc[0] ^ wb_pc[0];

  logic              lk_hit;
  logic [WAY_W-1:0]  lk_way;
  logic [ADDR_W-1:0] lk_tgt;

  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    lk_tgt = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
        lk_tgt = tgt_q[lk_idx][w];
      end
    end
  end

  logic              wb_hit, wb_has_free;
  logic [WAY_W-1:0]  wb_hit_way, wb_free_way, wb_victim, wb_way;

  always_comb begin
    wb_hit      = 1'b0;
    wb_hit_way  = '0;
    wb_has_free = 1'b0;
    wb_free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[wb_idx][w] && tag_q[wb_idx][w] == wb_tag) begin
        wb_hit     = 1'b1;
        wb_hit_way = WAY_W'(w);
      end
      if (!valid_q[wb_idx][w] && !wb_has_free) begin
        wb_has_free = 1'b1;
        wb_free_way = WAY_W'(w);
      end
    end
  end

  assign wb_way = wb_hit ? wb_hit_way : (wb_has_free ? wb_free_way : wb_victim);

  logic [PLRU_W-1:0] lk_plru_next, wb_plru_next;
  logic [WAY_W-1:0]  lk_victim_unused;

  plru_tree #(.WAYS(WAYS)) u_lk_plru (
    .plru      (plru_q[lk_idx]),
    .touch_way (lk_way),
    .plru_next (lk_plru_next),
    .victim    (lk_victim_unused)
  );

  plru_tree #(.WAYS(WAYS)) u_wb_plru (
    .plru      (plru_q[wb_idx]),
    .touch_way (wb_way),
    .plru_next (wb_plru_next),
    .victim    (wb_victim)
  );

  logic lk_touch, wb_fire;

  assign lk_touch = lk_valid && lk_hit && (state == BTB_IDLE);
  assign wb_fire  = wb_valid && wb_ready;

  // The update's PLRU write is ordered after the lookup's so it wins on a same-set collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      state      <= BTB_IDLE;
      flush_cnt  <= '0;
      flush_busy <= 1'b0;
      wb_ready   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_hit     <= 1'b0;
      rd_target  <= '0;
    end else begin
      rd_valid  <= lk_valid;
      rd_hit    <= lk_touch;
      rd_target <= lk_touch ? lk_tgt : '0;
      if (lk_touch) begin
        plru_q[lk_idx] <= lk_plru_next;
      end
      if (wb_fire) begin
        valid_q[wb_idx][wb_way] <= 1'b1;
        plru_q[wb_idx]          <= wb_plru_next;
      end
      case (state)
        BTB_IDLE: begin
          wb_ready <= !flush_req;
          if (flush_req) begin
            state      <= BTB_FLUSH;
            flush_cnt  <= '0;
            flush_busy <= 1'b1;
          end
        end
        BTB_FLUSH: begin
          valid_q[flush_cnt] <= '0;
          plru_q[flush_cnt]  <= '0;
          if (flush_cnt == IDX_W'(SETS - 1)) begin
            state      <= BTB_IDLE;
            flush_busy <= 1'b0;
            wb_ready   <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wb_fire) begin
      tag_q[wb_idx][wb_way] <= wb_tag;
      tgt_q[wb_idx][wb_way] <= wb_target;
    end
  end

endmodule

// File: tb/tb_btb_assoc_plru.sv
// tb/tb_btb_assoc_plru.sv - self-checking bench for btb_assoc_plru
module tb_btb_assoc_plru;

  localparam int WAYS = 4;
  localparam int SETS = 8;
  localparam int AW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lk_valid = 1'b0;
  logic [AW-1:0] lk_pc = '0;
  logic          rd_valid, rd_hit;
  logic [AW-1:0] rd_target;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [AW-1:0] wb_pc = '0;
  logic [AW-1:0] wb_target = '0;
  logic          flush_req = 1'b0;
  logic          flush_busy;

  always #5 clk = ~clk;

  btb_assoc_plru #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_valid   (lk_valid),
    .lk_pc      (lk_pc),
    .rd_valid   (rd_valid),
    .rd_hit     (rd_hit),
    .rd_target  (rd_target),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_pc      (wb_pc),
    .wb_target  (wb_target),
    .flush_req  (flush_req),
    .flush_busy (flush_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain arrays, PLRU tree walked by halving way ranges.
  bit m_valid [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int m_tgt   [SETS][WAYS];
  bit m_plru  [SETS][WAYS-1];
  bit m_flush;
  int m_cnt;
  bit m_ready;

  function automatic void m_touch(int s, int w);
    int node = 0, lo = 0, size = WAYS, half;
    while (size > 1) begin
      half = size / 2;
      if (w < lo + half) begin
        m_plru[s][node] = 1'b1;
        node = 2 * node + 1;
      end else begin
        m_plru[s][node] = 1'b0;
        node = 2 * node + 2;
        lo += half;
      end
      size = half;
    end
  endfunction

  function automatic int m_victim(int s);
    int node = 0, lo = 0, size = WAYS, half;
    while (size > 1) begin
      half = size / 2;
      if (!m_plru[s][node]) node = 2 * node + 1;
      else begin
        node = 2 * node + 2;
        lo += half;
      end
      size = half;
    end
    return lo;
  endfunction

  function automatic void m_clear_set(int s);
    for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    for (int n = 0; n < WAYS - 1; n++) m_plru[s][n] = 1'b0;
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++) m_clear_set(s);
    m_flush = 1'b0;
    m_cnt   = 0;
    m_ready = 1'b0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict one clock from the current inputs, advance it, then compare all outputs.
  task automatic cyc();
    int  s, t, ws, wt, hw, way, exp_t;
    bit  exp_h, fire;
    exp_h = 1'b0; exp_t = 0; hw = 0;
    s  = (int'(lk_pc) >> 1) % SETS;
    t  = int'(lk_pc) >> 4;
    ws = (int'(wb_pc) >> 1) % SETS;
    wt = int'(wb_pc) >> 4;
    if (lk_valid && !m_flush)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_tag[s][w] == t) begin
          exp_h = 1'b1; exp_t = m_tgt[s][w]; hw = w;
        end
    fire = wb_valid && m_ready;
    if (fire) begin
      way = -1;
      for (int w = 0; w < WAYS; w++) if (m_valid[ws][w] && m_tag[ws][w] == wt) way = w;
      for (int w = 0; w < WAYS; w++) if (way < 0 && !m_valid[ws][w]) way = w;
      if (way < 0) way = m_victim(ws);
      m_valid[ws][way] = 1'b1;
      m_tag[ws][way]   = wt;
      m_tgt[ws][way]   = int'(wb_target);
      m_touch(ws, way);
    end
    if (exp_h && !(fire && ws == s)) m_touch(s, hw);
    if (!m_flush) begin
      if (flush_req) begin m_flush = 1'b1; m_cnt = 0; end
    end else begin
      m_clear_set(m_cnt);
      if (m_cnt == SETS - 1) m_flush = 1'b0;
      else m_cnt++;
    end
    m_ready = !m_flush;
    @(posedge clk);
    #1;
    chk("rd_valid",   rd_valid,   lk_valid);
    chk("rd_hit",     rd_hit,     exp_h);
    chk("rd_target",  rd_target,  exp_t);
    chk("wb_ready",   wb_ready,   m_ready);
    chk("flush_busy", flush_busy, m_flush);
  endtask

  task automatic idle_inputs();
    lk_valid = 0; wb_valid = 0; flush_req = 0;
  endtask

  task automatic do_lookup(input int pc);
    idle_inputs(); lk_valid = 1; lk_pc = AW'(pc);
    cyc();
  endtask

  task automatic do_write(input int pc, input int tgt);
    idle_inputs(); wb_valid = 1; wb_pc = AW'(pc); wb_target = AW'(tgt);
    cyc();
  endtask

  typedef struct {
    bit lk_v; int lk_pc; bit wb_v; int wb_pc; int wb_tgt; bit exp_hit; int exp_tgt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit lv, int lp, bit wv, int wp, int wt, bit eh, int et);
    vec_t v;
    v.lk_v = lv; v.lk_pc = lp; v.wb_v = wv; v.wb_pc = wp; v.wb_tgt = wt;
    v.exp_hit = eh; v.exp_tgt = et;
    tbl.push_back(v);
  endfunction

  int prior_pcs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_valid",   rd_valid,   0);
    chk("reset_rd_hit",     rd_hit,     0);
    chk("reset_rd_target",  rd_target,  0);
    chk("reset_wb_ready",   wb_ready,   0);
    chk("reset_flush_busy", flush_busy, 0);
    rst_n = 1;

    add(1, 'h3000, 0, 0, 0, 0, 0);
    add(0, 0, 1, 'h3002, 'h3100, 0, 0);
    add(1, 'h3002, 0, 0, 0, 1, 'h3100);
    add(1, 'h3012, 0, 0, 0, 0, 0);
    add(0, 0, 1, 'h3002, 'h5002, 0, 0);
    add(0, 0, 1, 'h3012, 'h5012, 0, 0);
    add(0, 0, 1, 'h3022, 'h5022, 0, 0);
    add(0, 0, 1, 'h3032, 'h5032, 0, 0);
    add(1, 'h3002, 0, 0, 0, 1, 'h5002);
    add(0, 0, 1, 'h3042, 'h5042, 0, 0);
    add(1, 'h3022, 0, 0, 0, 0, 0);
    add(1, 'h3002, 0, 0, 0, 1, 'h5002);
    add(1, 'h3012, 0, 0, 0, 1, 'h5012);
    add(1, 'h3032, 0, 0, 0, 1, 'h5032);
    add(1, 'h3042, 0, 0, 0, 1, 'h5042);
    add(0, 0, 1, 'h3012, 'h4000, 0, 0);
    add(1, 'h3012, 0, 0, 0, 1, 'h4000);
    add(1, 'h3002, 0, 0, 0, 1, 'h5002);
    add(1, 'h3032, 0, 0, 0, 1, 'h5032);
    add(1, 'h3042, 1, 'h3042, 'h6000, 1, 'h5042);
    add(1, 'h3042, 0, 0, 0, 1, 'h6000);
    add(1, 'h3023, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      idle_inputs();
      lk_valid  = tbl[i].lk_v;
      lk_pc     = AW'(tbl[i].lk_pc);
      wb_valid  = tbl[i].wb_v;
      wb_pc     = AW'(tbl[i].wb_pc);
      wb_target = AW'(tbl[i].wb_tgt);
      cyc();
      if (tbl[i].lk_v) begin
        chk($sformatf("tbl%0d_hit", i), rd_hit, tbl[i].exp_hit);
        chk($sformatf("tbl%0d_tgt", i), rd_target, tbl[i].exp_tgt);
      end
    end

    // Flush: populate another set, pulse flush together with a write, probe during flush.
    do_write('h3106, 'h7106);
    prior_pcs = '{'h3002, 'h3012, 'h3032, 'h3042, 'h3106, 'h3208};
    idle_inputs(); flush_req = 1; wb_valid = 1; wb_pc = 'h3208; wb_target = 'h7208;
    cyc();
    n = 0;
    while (flush_busy && n < 20) begin
      idle_inputs(); lk_valid = 1; lk_pc = AW'(prior_pcs[n % 6]);
      wb_valid = 1; wb_pc = 'h3300; wb_target = 'h7300;
      flush_req = (n == 2);
      cyc();
      chk($sformatf("flush%0d_rd_valid", n), rd_valid, 1);
      chk($sformatf("flush%0d_rd_hit", n), rd_hit, 0);
      n++;
    end
    chk("flush_len", n, 8);
    foreach (prior_pcs[i]) begin
      do_lookup(prior_pcs[i]);
      chk($sformatf("post_flush_miss%0d", i), rd_hit, 0);
    end
    do_lookup('h3300);
    chk("flush_wb_ignored", rd_hit, 0);

    // Reset in the middle of a flush.
    do_write('h3004, 'h8004);
    do_write('h3016, 'h8016);
    idle_inputs(); flush_req = 1;
    cyc();
    idle_inputs();
    cyc();
    cyc();
    #3;
    rst_n = 0;
    #1;
    chk("rst_mid_flush_busy",  flush_busy, 0);
    chk("rst_mid_wb_ready",    wb_ready,   0);
    chk("rst_mid_rd_valid",    rd_valid,   0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    m_reset();
    do_lookup('h3004);
    chk("rst_after_miss_a", rd_hit, 0);
    chk("rst_after_ready",  wb_ready, 1);
    do_lookup('h3016);
    chk("rst_after_miss_b", rd_hit, 0);
    do_lookup('h3002);
    chk("rst_after_miss_c", rd_hit, 0);

    // Random traffic against the model, with a tag pool larger than the associativity.
    for (int i = 0; i < 2000; i++) begin
      lk_valid  = ($urandom_range(0, 3) != 0);
      lk_pc     = AW'('h3000 | ($urandom_range(0, 5) << 4) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
      wb_valid  = ($urandom_range(0, 1) != 0);
      wb_pc     = AW'('h3000 | ($urandom_range(0, 5) << 4) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
      wb_target = AW'($urandom_range(0, 'hffff));
      flush_req = ($urandom_range(0, 99) == 0);
      cyc();
    end

    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
